// File: rtl/cu_data_write_packer_pkg.sv
// Shared command/data-line types for the compute-unit write-data path.
package cu_data_write_packer_pkg;

  localparam logic [7:0] DATA_WRITE_CONTROL_ID = 8'h21;

  typedef enum logic [1:0] {CMD_INVALID, CMD_READ, CMD_WRITE, CMD_PREFETCH} command_type;
  typedef enum logic [2:0] {STRUCT_INVALID, READ_DATA, WRITE_DATA, READ_INDEX, WRITE_INDEX} array_struct_type;
  typedef enum logic [0:0] {STRICT, RELAXED} abt_type;

  typedef struct packed {
    logic [7:0]       cu_id;
    command_type      cmd_type;
    logic [5:0]       real_size;
    logic [63:0]      address_offest;
    logic [6:0]       cacheline_offest;
    array_struct_type array_struct;
    abt_type          abt;
  } CommandBufferLine;

  typedef struct packed {
    logic             valid;
    CommandBufferLine cmd;
    logic [511:0]     data;
  } ReadWriteDataLine;

  typedef struct packed {
    logic alfull;
    logic full;
    logic empty;
  } BufferStatus;

endpackage

// File: rtl/cu_data_write_packer.sv
// Packs a stream of elements into 128-byte cachelines (two 64-byte halves)
// and emits each completed or flushed line for one cycle as a write command.
module cu_data_write_packer
  import cu_data_write_packer_pkg::*;
#(
  parameter logic [7:0] CU_WRITE_CONTROL_ID = DATA_WRITE_CONTROL_ID,
  parameter int         ELEM_BITS           = 32
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 enabled_in,
  input  logic                 element_valid_in,
  input  logic [ELEM_BITS-1:0] element_data_in,
  input  logic                 flush_in,
  input  BufferStatus          write_data_in_buffer_status,
  output logic                 element_ready_out,
  output ReadWriteDataLine     write_data_0_out,
  output ReadWriteDataLine     write_data_1_out,
  output logic                 flush_done_out,
  output logic [63:0]          lines_emitted_out
);

  localparam int LINE_ELEMS = 32;
  localparam int SLOT_BITS  = 32;

  typedef enum logic [1:0] {FILL, EMIT, HOLD} state_e;
  typedef logic [LINE_ELEMS-1:0][SLOT_BITS-1:0] line_t;

  state_e           state_q;
  logic             en_q, pend_q, tag_q, fdone_q;
  logic [5:0]       cnt_q;
  line_t            line_q;
  logic [63:0]      idx_q, lines_q;
  ReadWriteDataLine wd0_q, wd1_q;

  logic       accept, flush_w, close_w, alfull;
  logic [5:0] cnt_d;
  line_t      line_d;
  logic       unused_status;

  assign alfull        = write_data_in_buffer_status.alfull;
  assign unused_status = ^write_data_in_buffer_status;

  assign element_ready_out = en_q && (state_q == FILL) && !pend_q;
  assign accept            = element_valid_in && element_ready_out;
  assign flush_w           = flush_in || pend_q;

  // Line as it stands after this cycle's acceptance, so a same-cycle flush
  // or the 32nd element lands in the emitted line.
  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (accept) begin
      line_d[cnt_q[4:0]] = SLOT_BITS'(element_data_in);
      cnt_d              = cnt_q + 6'd1;
    end
  end

  assign close_w = (cnt_d == 6'd32) || (flush_w && (cnt_d != 6'd0));

  function automatic ReadWriteDataLine half_line(input line_t ln, input logic upper,
                                                 input logic [5:0] n, input logic [63:0] idx);
    ReadWriteDataLine r;
    r                    = '0;
    r.valid              = 1'b1;
    r.cmd.cu_id          = CU_WRITE_CONTROL_ID;
    r.cmd.cmd_type       = CMD_WRITE;
    r.cmd.real_size      = n;
    r.cmd.address_offest = idx << 7;
    r.cmd.array_struct   = WRITE_DATA;
    r.cmd.abt            = STRICT;
    r.data               = upper ? ln[31:16] : ln[15:0];
    return r;
  endfunction

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= FILL;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      tag_q   <= 1'b0;
      fdone_q <= 1'b0;
      cnt_q   <= '0;
      line_q  <= '0;
      idx_q   <= '0;
      lines_q <= '0;
      wd0_q   <= '0;
      wd1_q   <= '0;
    end else begin
      en_q    <= enabled_in;
      fdone_q <= 1'b0;
      wd0_q   <= '0;
      wd1_q   <= '0;
      case (state_q)
        FILL: begin
          if (en_q) begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
            if (close_w) begin
              tag_q  <= flush_w;
              pend_q <= 1'b0;
              if (alfull) begin
                state_q <= HOLD;
              end else begin
                state_q <= EMIT;
                wd0_q   <= half_line(line_d, 1'b0, cnt_d, idx_q);
                wd1_q   <= half_line(line_d, 1'b1, cnt_d, idx_q);
                fdone_q <= flush_w;
              end
            end else if (flush_w) begin
              fdone_q <= 1'b1;
              pend_q  <= 1'b0;
            end
          end else begin
            // Frozen while disabled; a flush is kept until we can act on it.
            pend_q <= pend_q || flush_in;
          end
        end
        HOLD: begin
          pend_q <= pend_q || flush_in;
          if (!alfull) begin
            state_q <= EMIT;
            wd0_q   <= half_line(line_q, 1'b0, cnt_q, idx_q);
            wd1_q   <= half_line(line_q, 1'b1, cnt_q, idx_q);
            fdone_q <= tag_q;
          end
        end
        EMIT: begin
          pend_q  <= pend_q || flush_in;
          state_q <= FILL;
          cnt_q   <= '0;
          line_q  <= '0;
          tag_q   <= 1'b0;
          idx_q   <= idx_q + 64'd1;
          lines_q <= lines_q + 64'd1;
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign write_data_0_out  = wd0_q;
  assign write_data_1_out  = wd1_q;
  assign flush_done_out    = fdone_q;
  assign lines_emitted_out = lines_q;

endmodule

// File: tb/tb_cu_data_write_packer.sv
// Bench for cu_data_write_packer: directed scenarios plus a randomized run
// scored against a queue-based model of line packing.
module tb_cu_data_write_packer;
  import cu_data_write_packer_pkg::*;

  logic             clock = 1'b0;
  logic             rstn = 1'b0;
  logic             enabled_in = 1'b0;
  logic             element_valid_in = 1'b0;
  logic [31:0]      element_data_in = '0;
  logic             flush_in = 1'b0;
  BufferStatus      bstat = '0;
  logic             element_ready_out, flush_done_out;
  ReadWriteDataLine write_data_0_out, write_data_1_out;
  logic [63:0]      lines_emitted_out;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int nz_err = 0, vmis = 0;
  ReadWriteDataLine q0[$], q1[$];
  int               qcyc[$], fd_cyc[$];
  logic             qfd[$];
  logic [31:0]      sent[$];

  cu_data_write_packer dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
    .element_valid_in(element_valid_in), .element_data_in(element_data_in),
    .flush_in(flush_in), .write_data_in_buffer_status(bstat),
    .element_ready_out(element_ready_out), .write_data_0_out(write_data_0_out),
    .write_data_1_out(write_data_1_out), .flush_done_out(flush_done_out),
    .lines_emitted_out(lines_emitted_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Recorder: captures every emitted line and flush_done pulse with its cycle.
  always @(posedge clock) begin
    #1;
    if ((write_data_0_out.valid !== write_data_1_out.valid) ||
        (write_data_0_out.valid && (write_data_0_out.cmd !== write_data_1_out.cmd))) vmis++;
    if (write_data_0_out.valid === 1'b1) begin
      q0.push_back(write_data_0_out); q1.push_back(write_data_1_out);
      qcyc.push_back(cyc); qfd.push_back(flush_done_out);
    end else if (write_data_0_out !== '0 || write_data_1_out !== '0) nz_err++;
    if (flush_done_out === 1'b1) fd_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic clear_rec();
    q0.delete(); q1.delete(); qcyc.delete(); qfd.delete(); fd_cyc.delete(); sent.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0; element_valid_in = 1'b0; flush_in = 1'b0; bstat = '0; enabled_in = 1'b1;
    tick(); tick(); rstn = 1'b1; tick();
    clear_rec();
  endtask

  task automatic send(input int n, input bit rnd, output int last_edge, output int cycles);
    int got = 0; bit acc; logic [31:0] v;
    cycles = 0; last_edge = -1;
    while (got < n && cycles < 400) begin
      v = rnd ? $urandom : 32'(got);
      element_valid_in = 1'b1; element_data_in = v; acc = element_ready_out;
      tick(); cycles++;
      if (acc) begin sent.push_back(v); got++; last_edge = cyc; end
    end
    element_valid_in = 1'b0;
    if (got < n) begin n_cmp++; n_bad++; $display("FAIL send_timeout: accepted %0d of %0d", got, n); end
  endtask

  // Reference half-line: element k of the line sits in half k/16, slot k%16.
  function automatic ReadWriteDataLine exp_half(input int half, input logic [31:0] el[$],
                                                input int start, input int n, input longint unsigned idx);
    ReadWriteDataLine r = '0;
    r.valid = 1'b1;
    r.cmd.cu_id = DATA_WRITE_CONTROL_ID; r.cmd.cmd_type = CMD_WRITE;
    r.cmd.real_size = 6'(n); r.cmd.address_offest = 64'(idx) * 64'd128;
    r.cmd.array_struct = WRITE_DATA; r.cmd.abt = STRICT;
    for (int k = 0; k < n; k++) if (k / 16 == half) r.data[32*(k%16) +: 32] = el[start+k];
    return r;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; tick(); tick();
    n_cmp++; if (element_ready_out !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", element_ready_out); end
    n_cmp++; if (write_data_0_out !== '0) begin n_bad++; $display("FAIL rst_wd0: got %h want 0", write_data_0_out); end
    n_cmp++; if (write_data_1_out !== '0) begin n_bad++; $display("FAIL rst_wd1: got %h want 0", write_data_1_out); end
    n_cmp++; if (flush_done_out !== 1'b0) begin n_bad++; $display("FAIL rst_fdone: got %b want 0", flush_done_out); end
    n_cmp++; if (lines_emitted_out !== 64'd0) begin n_bad++; $display("FAIL rst_lines: got %0d want 0", lines_emitted_out); end
  endtask

  task automatic test_full_line();
    int l, cy; ReadWriteDataLine e0, e1;
    do_reset();
    send(32, 1'b0, l, cy);
    repeat (3) tick();
    e0 = exp_half(0, sent, 0, 32, 0); e1 = exp_half(1, sent, 0, 32, 0);
    n_cmp++; if (cy !== 32) begin n_bad++; $display("FAIL full_b2b_cycles: got %0d want 32", cy); end
    n_cmp++; if (q0.size() !== 1) begin n_bad++; $display("FAIL full_nlines: got %0d want 1", q0.size()); end
    if (q0.size() > 0) begin
      n_cmp++; if (qcyc[0] !== l) begin n_bad++; $display("FAIL full_emit_cycle: got %0d want %0d", qcyc[0], l); end
      n_cmp++; if (q0[0] !== e0) begin n_bad++; $display("FAIL full_half0: got %h want %h", q0[0], e0); end
      n_cmp++; if (q1[0] !== e1) begin n_bad++; $display("FAIL full_half1: got %h want %h", q1[0], e1); end
      n_cmp++; if (q0[0].data[31:0] !== 32'd0) begin n_bad++; $display("FAIL full_h0s0: got %0d want 0", q0[0].data[31:0]); end
      n_cmp++; if (q1[0].data[511:480] !== 32'd31) begin n_bad++; $display("FAIL full_h1s15: got %0d want 31", q1[0].data[511:480]); end
    end
    n_cmp++; if (lines_emitted_out !== 64'd1) begin n_bad++; $display("FAIL full_lines: got %0d want 1", lines_emitted_out); end
  endtask

  task automatic test_flush_partial();
    int l, cy, f; ReadWriteDataLine e;
    do_reset();
    send(40, 1'b1, l, cy);
    flush_in = 1'b1; tick(); f = cyc; flush_in = 1'b0;
    repeat (3) tick();
    n_cmp++; if (q0.size() !== 2) begin n_bad++; $display("FAIL fp_nlines: got %0d want 2", q0.size()); end
    if (q0.size() == 2) begin
      e = exp_half(0, sent, 0, 32, 0);
      n_cmp++; if (q0[0] !== e) begin n_bad++; $display("FAIL fp_l0h0: got %h want %h", q0[0], e); end
      e = exp_half(0, sent, 32, 8, 1);
      n_cmp++; if (q0[1] !== e) begin n_bad++; $display("FAIL fp_l1h0: got %h want %h", q0[1], e); end
      e = exp_half(1, sent, 32, 8, 1);
      n_cmp++; if (q1[1] !== e) begin n_bad++; $display("FAIL fp_l1h1: got %h want %h", q1[1], e); end
      n_cmp++; if ({qfd[0], qfd[1]} !== 2'b01) begin n_bad++; $display("FAIL fp_fdone_tag: got %b%b want 01", qfd[0], qfd[1]); end
      n_cmp++; if (qcyc[1] !== f) begin n_bad++; $display("FAIL fp_emit_cycle: got %0d want %0d", qcyc[1], f); end
    end
    n_cmp++; if (fd_cyc.size() !== 1) begin n_bad++; $display("FAIL fp_fdone_count: got %0d want 1", fd_cyc.size()); end
    n_cmp++; if (lines_emitted_out !== 64'd2) begin n_bad++; $display("FAIL fp_lines: got %0d want 2", lines_emitted_out); end
  endtask

  task automatic test_hold();
    int l, cy, d; ReadWriteDataLine e;
    do_reset();
    bstat.alfull = 1'b1;
    send(32, 1'b1, l, cy);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (element_ready_out !== 1'b0 || q0.size() !== 0) begin
        n_bad++; $display("FAIL hold_idle%0d: got ready=%b lines=%0d want ready=0 lines=0", i, element_ready_out, q0.size());
      end
      tick();
    end
    bstat.alfull = 1'b0; d = cyc;
    repeat (3) tick();
    n_cmp++; if (q0.size() !== 1) begin n_bad++; $display("FAIL hold_nlines: got %0d want 1", q0.size()); end
    if (q0.size() > 0) begin
      e = exp_half(1, sent, 0, 32, 0);
      n_cmp++; if (qcyc[0] !== d + 1) begin n_bad++; $display("FAIL hold_emit_cycle: got %0d want %0d", qcyc[0], d + 1); end
      n_cmp++; if (q1[0] !== e) begin n_bad++; $display("FAIL hold_half1: got %h want %h", q1[0], e); end
    end
  endtask

  task automatic test_flush_empty();
    int c;
    do_reset();
    flush_in = 1'b1; c = cyc; tick(); flush_in = 1'b0;
    repeat (3) tick();
    n_cmp++; if (fd_cyc.size() !== 1) begin n_bad++; $display("FAIL fe_fdone_count: got %0d want 1", fd_cyc.size()); end
    else begin
      n_cmp++; if (fd_cyc[0] !== c + 1) begin n_bad++; $display("FAIL fe_fdone_cycle: got %0d want %0d", fd_cyc[0], c + 1); end
    end
    n_cmp++; if (q0.size() !== 0) begin n_bad++; $display("FAIL fe_nlines: got %0d want 0", q0.size()); end
    n_cmp++; if (lines_emitted_out !== 64'd0) begin n_bad++; $display("FAIL fe_lines: got %0d want 0", lines_emitted_out); end
  endtask

  task automatic test_pending_flush();
    int l, cy, e;
    do_reset();
    bstat.alfull = 1'b1;
    send(32, 1'b1, l, cy);
    flush_in = 1'b1; tick(); flush_in = 1'b0;
    bstat.alfull = 1'b0; e = cyc + 1;
    tick(); tick();
    n_cmp++; if (element_ready_out !== 1'b0) begin n_bad++; $display("FAIL pf_ready: got %b want 0", element_ready_out); end
    repeat (3) tick();
    n_cmp++; if (q0.size() !== 1) begin n_bad++; $display("FAIL pf_nlines: got %0d want 1", q0.size()); end
    if (q0.size() > 0) begin
      n_cmp++; if (qcyc[0] !== e || qfd[0] !== 1'b0) begin
        n_bad++; $display("FAIL pf_emit: got cyc=%0d fd=%b want cyc=%0d fd=0", qcyc[0], qfd[0], e);
      end
    end
    n_cmp++; if (fd_cyc.size() !== 1) begin n_bad++; $display("FAIL pf_fdone_count: got %0d want 1", fd_cyc.size()); end
    else begin
      n_cmp++; if (fd_cyc[0] !== e + 2) begin n_bad++; $display("FAIL pf_fdone_cycle: got %0d want %0d", fd_cyc[0], e + 2); end
    end
    n_cmp++; if (element_ready_out !== 1'b1) begin n_bad++; $display("FAIL pf_ready_after: got %b want 1", element_ready_out); end
  endtask

  task automatic test_random();
    ReadWriteDataLine exp0[$], exp1[$];
    logic expfd[$];
    logic [31:0] cur[$];
    longint unsigned idx = 0;
    int nflush = 0;
    bit rdy;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      enabled_in = ($urandom_range(9) != 0);
      bstat.alfull = ($urandom_range(3) == 0);
      element_valid_in = $urandom_range(1);
      element_data_in = $urandom;
      rdy = element_ready_out;
      flush_in = rdy && ($urandom_range(19) == 0);
      if (element_valid_in && rdy) cur.push_back(element_data_in);
      if (flush_in || cur.size() == 32) begin
        if (cur.size() > 0) begin
          exp0.push_back(exp_half(0, cur, 0, cur.size(), idx));
          exp1.push_back(exp_half(1, cur, 0, cur.size(), idx));
          expfd.push_back(flush_in);
          idx++; cur.delete();
        end
        if (flush_in) nflush++;
      end
      tick();
    end
    element_valid_in = 1'b0; flush_in = 1'b0; bstat.alfull = 1'b0; enabled_in = 1'b1;
    repeat (10) tick();
    n_cmp++; if (q0.size() !== exp0.size()) begin n_bad++; $display("FAIL rnd_nlines: got %0d want %0d", q0.size(), exp0.size()); end
    for (int i = 0; i < q0.size() && i < exp0.size(); i++) begin
      n_cmp++; if (q0[i] !== exp0[i] || q1[i] !== exp1[i] || qfd[i] !== expfd[i]) begin
        n_bad++; $display("FAIL rnd_line%0d: got %h/%h fd=%b want %h/%h fd=%b", i, q0[i].cmd, q1[i].data[63:0], qfd[i], exp0[i].cmd, exp1[i].data[63:0], expfd[i]);
      end
    end
    n_cmp++; if (fd_cyc.size() !== nflush) begin n_bad++; $display("FAIL rnd_fdone_count: got %0d want %0d", fd_cyc.size(), nflush); end
    n_cmp++; if (lines_emitted_out !== 64'(exp0.size())) begin n_bad++; $display("FAIL rnd_lines: got %0d want %0d", lines_emitted_out, exp0.size()); end
  endtask

  task automatic test_reset_mid();
    int l, cy; ReadWriteDataLine e;
    send(10, 1'b1, l, cy);
    rstn = 1'b0; #1;
    n_cmp++; if (element_ready_out !== 1'b0 || flush_done_out !== 1'b0) begin
      n_bad++; $display("FAIL rm_ctrl: got ready=%b fd=%b want 0 0", element_ready_out, flush_done_out);
    end
    n_cmp++; if (write_data_0_out !== '0 || write_data_1_out !== '0) begin n_bad++; $display("FAIL rm_wd: got valid %b%b want 00", write_data_0_out.valid, write_data_1_out.valid); end
    n_cmp++; if (lines_emitted_out !== 64'd0) begin n_bad++; $display("FAIL rm_lines: got %0d want 0", lines_emitted_out); end
    tick(); rstn = 1'b1; tick();
    clear_rec();
    send(32, 1'b1, l, cy);
    repeat (3) tick();
    n_cmp++; if (q0.size() !== 1) begin n_bad++; $display("FAIL rm_nlines: got %0d want 1", q0.size()); end
    if (q0.size() > 0) begin
      e = exp_half(0, sent, 0, 32, 0);
      n_cmp++; if (q0[0] !== e) begin n_bad++; $display("FAIL rm_half0: got %h want %h", q0[0], e); end
      e = exp_half(1, sent, 0, 32, 0);
      n_cmp++; if (q1[0] !== e) begin n_bad++; $display("FAIL rm_half1: got %h want %h", q1[0], e); end
    end
  endtask

  task automatic test_idle_zero();
    n_cmp++; if (nz_err !== 0) begin n_bad++; $display("FAIL idle_nonzero: got %0d cycles want 0", nz_err); end
    n_cmp++; if (vmis !== 0) begin n_bad++; $display("FAIL half_pairing: got %0d cycles want 0", vmis); end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_flush_partial();
    test_hold();
    test_flush_empty();
    test_pending_flush();
    test_random();
    test_reset_mid();
    test_idle_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cu_data_write_packer.md
CU_DATA_WRITE_PACKER -- requirements
Module: cu_data_write_packer

Interface
REQ-001 SHALL have parameter CU_WRITE_CONTROL_ID, default DATA_WRITE_CONTROL_ID, stamped into cmd.cu_id of every emitted line.
REQ-002 SHALL have parameter ELEM_BITS, default 32, giving the element width.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port enabled_in  input  1  enable; registered one cycle before use.
REQ-006 SHALL have port element_valid_in  input  1  an element is offered this cycle.
REQ-007 SHALL have port element_data_in  input  ELEM_BITS  the element payload.
REQ-008 SHALL have port flush_in  input  1  single-cycle pulse that closes the current partial line.
REQ-009 SHALL have port write_data_in_buffer_status  input  BufferStatus  downstream write-data FIFO status; only .alfull is used.
REQ-010 SHALL have port element_ready_out  output  1  the element is accepted when valid and ready are both high.
REQ-011 SHALL have port write_data_0_out  output  ReadWriteDataLine  lower half-cacheline (elements 0-15).
REQ-012 SHALL have port write_data_1_out  output  ReadWriteDataLine  upper half-cacheline (elements 16-31).
REQ-013 SHALL have port flush_done_out  output  1  one-cycle pulse when a flush has completed.
REQ-014 SHALL have port lines_emitted_out  output  64  running count of emitted lines.

Function
REQ-015 SHALL pack 32 elements per 128-byte cacheline; element k goes to half k/16, at bits [32*(k%16) : 32*(k%16)+31] of .data.
REQ-016 SHALL implement a three-state FSM:
- FILL: accepting elements.
- EMIT: driving the line for one cycle.
- HOLD: line complete but downstream .alfull is high.
REQ-017 SHALL drive element_ready_out = enabled_registered AND state==FILL AND no pending flush.
REQ-018 SHALL, in FILL, on acceptance of element 31 (count reaches 32), go to EMIT if .alfull is low next cycle, else go to HOLD.
REQ-019 SHALL, in FILL, on flush_in with count>0, close the partial line through the same EMIT/HOLD path; an element accepted in the same cycle as flush_in is included.
REQ-020 SHALL, on flush_in with count==0, emit nothing and pulse flush_done_out the next cycle.
REQ-021 SHALL, in HOLD, stay while .alfull is high and go to EMIT in the first cycle it is low.
REQ-022 SHALL, in EMIT, assert both .valid outputs for exactly one cycle with identical cmd, then clear count and return to FILL.
REQ-023 SHALL, on the EMIT that follows a flush, pulse flush_done_out in that same cycle.
REQ-024 SHALL set cmd for each emitted line as follows:
- real_size = element count (1..32).
- address_offest = line_index*128 bytes; line_index starts at 0 and wraps modulo 2^64.
- cacheline_offest = 0.
- array_struct = WRITE_DATA.
- cmd_type = CMD_WRITE.
- abt = STRICT.
REQ-025 SHALL zero unused element slots of a partial line.
REQ-026 SHALL increment lines_emitted_out once per EMIT, wrapping modulo 2^64.
REQ-027 SHALL, when enabled drops, freeze FSM, count and line contents and deassert ready; a pending EMIT is still performed.
REQ-028 SHALL hold both write_data outputs at 0 (valid low) in every non-EMIT cycle.
REQ-029 SHALL ignore flush_in arriving in EMIT or HOLD and latch it as pending, applying it when FILL is re-entered.

Reset
REQ-030 SHALL, on rstn low, asynchronously reset all state:
- FSM to FILL.
- count, line_index and lines_emitted_out to 0.
- write_data_0_out and write_data_1_out to 0.
- element_ready_out, flush_done_out and pending flush to 0.
REQ-031 SHALL discard a partially filled or held line on reset mid-operation, without emitting it.

Verification
REQ-032 SHALL cover: 32 elements, values 0..31, back-to-back, alfull=0 -> one EMIT with real_size=32, address_offest=0, half0 slot0=0, half1 slot15=31, lines_emitted_out=1.
REQ-033 SHALL cover: 40 elements then flush_in -> two lines, second with real_size=8 and address_offest=128, slots 8-31 zero, flush_done_out pulses with the second EMIT.
REQ-034 SHALL cover: alfull held high when element 31 is accepted for 5 cycles -> HOLD, ready low, no valid; EMIT in the first cycle after alfull falls.
REQ-035 SHALL cover: flush_in with count=0 -> no valid, flush_done_out one cycle later, lines_emitted_out unchanged.
REQ-036 SHALL cover: rstn asserted after 10 accepted elements -> all outputs 0 immediately; after release, 32 new elements emit with address_offest=0.
